// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one external N-bit adder between two requesters.
// Operands are registered into the adder; the result is captured into a held response.
module adder_share_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_sub,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic [N-1:0] resp_sum,
  output logic         resp_cout,
  output logic         resp_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] op_a_q, op_a_d;
  logic [N-1:0] op_b_q, op_b_d;
  logic         op_cin_q, op_cin_d;
  logic         op_id_q, op_id_d;
  logic         last_grant_q, last_grant_d;
  logic         resp_valid_q, resp_valid_d;
  logic         resp_id_q, resp_id_d;
  logic [N-1:0] resp_sum_q, resp_sum_d;
  logic         resp_cout_q, resp_cout_d;
  logic         resp_ovf_q, resp_ovf_d;
  logic         grant0, grant1;
  logic         acc0, acc1;

  // Requester 0 wins unless requester 1 is also valid and 0 was granted last.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant_q);
    grant1 = req1_valid && !grant0;
  end

  assign req0_ready = !rst && (state_q == IDLE) && grant0;
  assign req1_ready = !rst && (state_q == IDLE) && grant1;
  assign acc0       = req0_ready;
  assign acc1       = req1_ready;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_cin_d     = op_cin_q;
    op_id_d      = op_id_q;
    last_grant_d = last_grant_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_sum_d   = resp_sum_q;
    resp_cout_d  = resp_cout_q;
    resp_ovf_d   = resp_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (acc0 || acc1) begin
          op_a_d       = acc1 ? req1_a : req0_a;
          op_b_d       = acc1 ? (req1_sub ? ~req1_b : req1_b) : (req0_sub ? ~req0_b : req0_b);
          op_cin_d     = acc1 ? req1_sub : req0_sub;
          op_id_d      = acc1;
          last_grant_d = acc1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        // op_b already holds ~b for subtraction, so this is the overflow of the actual op.
        resp_sum_d   = add_sum;
        resp_cout_d  = add_cout;
        resp_ovf_d   = (op_a_q[N-1] == op_b_q[N-1]) && (add_sum[N-1] != op_a_q[N-1]);
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_cin_q     <= 1'b0;
      op_id_q      <= 1'b0;
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_cout_q  <= 1'b0;
      resp_ovf_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_cin_q     <= op_cin_d;
      op_id_q      <= op_id_d;
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_sum_q   <= resp_sum_d;
      resp_cout_q  <= resp_cout_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign add_a      = op_a_q;
  assign add_b      = op_b_q;
  assign add_cin    = op_cin_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_sum   = resp_sum_q;
  assign resp_cout  = resp_cout_q;
  assign resp_ovf   = resp_ovf_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl: arithmetic reference model plus a
// cycle-level handshake model, with directed scenarios followed by random traffic.
module tb_adder_share_ctrl;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid, req0_ready, req0_sub;
  logic         req1_valid, req1_ready, req1_sub;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [N-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         resp_valid, resp_ready, resp_id, resp_cout, resp_ovf;
  logic [N-1:0] resp_sum;
  logic [N:0]   add_full;

  adder_share_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_ovf(resp_ovf)
  );

  // The shared adder itself.
  assign add_full = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};
  assign add_sum  = add_full[N-1:0];
  assign add_cout = add_full[N];

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  logic         gq[$];
  int           total = 0;
  int           bad = 0;
  int           phase = 0;   // 0 idle, 1 computing, 2 response held
  logic         lg = 1'b1;
  bit           acc[2];
  bit           rec = 1'b0;
  bit           g0, g1;
  exp_t         last_resp;
  bit           pend[2];
  logic [N-1:0] pa[2], pb[2];
  logic         ps[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    exp_t   e;
    longint sa, sbv, r, mx, mn;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    r   = sub ? sa - sbv : sa + sbv;
    mx  = (longint'(1) <<< (N - 1)) - 1;
    mn  = -(longint'(1) <<< (N - 1));
    e.id   = id;
    e.sum  = sub ? a - b : a + b;
    e.cout = sub ? (a >= b) : ((64'(a) + 64'(b)) >= (64'(1) << N));
    e.ovf  = (r > mx) || (r < mn);
    return e;
  endfunction

  // Monitor: predicts ready/valid from the handshake model and scores responses.
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
      lg    = 1'b1;
      sb.delete();
      acc[0] = 0;
      acc[1] = 0;
    end else begin
      g0 = (phase == 0) && req0_valid && (!req1_valid || lg);
      g1 = (phase == 0) && req1_valid && !g0;
      chk("req0_ready", 64'(req0_ready), 64'(g0));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      chk("resp_valid", 64'(resp_valid), 64'(phase == 2));
      if (req0_ready || req1_ready) if (rec) gq.push_back(req1_ready);
      if (phase == 2) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 64'(1), 64'(0));
        end else begin
          chk("resp_id",   64'(resp_id),   64'(sb[0].id));
          chk("resp_sum",  64'(resp_sum),  64'(sb[0].sum));
          chk("resp_cout", 64'(resp_cout), 64'(sb[0].cout));
          chk("resp_ovf",  64'(resp_ovf),  64'(sb[0].ovf));
          if (resp_ready) begin
            last_resp = {resp_id, resp_sum, resp_cout, resp_ovf};
            void'(sb.pop_front());
            phase = 0;
          end
        end
      end else if (phase == 1) begin
        phase = 2;
      end else if (g0 || g1) begin
        if (g1) sb.push_back(model(1'b1, req1_a, req1_b, req1_sub));
        else    sb.push_back(model(1'b0, req0_a, req0_b, req0_sub));
        lg = g1;
        phase = 1;
        acc[g1] = 1;
      end
    end
  end

  task automatic drive();
    req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0]; req0_sub = ps[0];
    req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1]; req1_sub = ps[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) if (acc[r]) begin pend[r] = 0; acc[r] = 0; end
  endtask

  task automatic post(input int r, input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    pend[r] = 1; pa[r] = a; pb[r] = b; ps[r] = s;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    drive();
    while ((pend[0] || pend[1] || phase != 0) && n < budget) begin
      tick(); drive(); n++;
    end
    chk("idle_timeout", 64'(n >= budget), 64'(0));
  endtask

  task automatic wait_phase(input int p);
    int n;
    n = 0;
    while (phase != p && n < 20) begin tick(); drive(); n++; end
    chk("phase_timeout", 64'(n >= 20), 64'(0));
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1; pend[0] = 0; pend[1] = 0; drive();
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [N-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return '0;
      3: return '1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_ready = 1'b1;
    pend[0] = 0; pend[1] = 0;
    pa[0] = '0; pb[0] = '0; ps[0] = 0; pa[1] = '0; pb[1] = '0; ps[1] = 0;
    // Reset state, with both requesters valid to prove ready is gated by rst.
    post(0, 32'd1, 32'd2, 1'b0); post(1, 32'd3, 32'd4, 1'b1); drive();
    @(negedge clk); @(negedge clk);
    chk("rst_req0_ready", 64'(req0_ready), 64'(0));
    chk("rst_req1_ready", 64'(req1_ready), 64'(0));
    chk("rst_add_a",      64'(add_a),      64'(0));
    chk("rst_add_b",      64'(add_b),      64'(0));
    chk("rst_add_cin",    64'(add_cin),    64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_sum",   64'(resp_sum),   64'(0));
    chk("rst_resp_flags", 64'({resp_id, resp_cout, resp_ovf}), 64'(0));
    pend[0] = 0; pend[1] = 0; drive();
    @(posedge clk); #1; rst = 1'b0;

    // Directed arithmetic.
    post(0, 32'd5, 32'd7, 1'b0); wait_idle(20);
    chk("add5_7", 64'(last_resp), 64'({1'b0, 32'd12, 1'b0, 1'b0}));
    post(1, 32'h3, 32'h5, 1'b1); wait_idle(20);
    chk("sub3_5", 64'(last_resp), 64'({1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0}));
    post(0, 32'h7FFF_FFFF, 32'h1, 1'b0); wait_idle(20);
    chk("add_ovf", 64'(last_resp), 64'({1'b0, 32'h8000_0000, 1'b0, 1'b1}));
    post(0, 32'h8000_0000, 32'h1, 1'b1); wait_idle(20);
    chk("sub_ovf", 64'(last_resp), 64'({1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1}));

    // Contention from reset: grants must alternate starting with requester 0.
    pulse_reset();
    gq.delete(); rec = 1;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < 2; r++) if (!pend[r]) post(r, $urandom, $urandom, 1'($urandom));
      drive(); tick();
    end
    rec = 0; pend[0] = 0; pend[1] = 0; wait_idle(20);
    chk("contend_count", 64'(gq.size() >= 5), 64'(1));
    for (int i = 0; i < gq.size(); i++) chk("contend_order", 64'(gq[i]), 64'(i % 2));

    // Backpressure with a request waiting behind the held response.
    resp_ready = 1'b0;
    post(0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1); drive();
    wait_phase(2);
    post(1, 32'h1111_1111, 32'h2222_2222, 1'b0); drive();
    for (int i = 0; i < 10; i++) tick();
    chk("bp_held", 64'(phase), 64'(2));
    resp_ready = 1'b1;
    wait_idle(20);

    // Reset during EXEC drops the operation and restarts arbitration.
    post(1, 32'h55, 32'h66, 1'b0); drive();
    wait_phase(1);
    rst = 1'b1; pend[0] = 0; pend[1] = 0; drive();
    #1;
    chk("midrst_add_a",   64'(add_a),   64'(0));
    chk("midrst_add_b",   64'(add_b),   64'(0));
    chk("midrst_add_cin", 64'(add_cin), 64'(0));
    tick(); tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    gq.delete(); rec = 1;
    post(0, 32'h10, 32'h20, 1'b0); post(1, 32'h30, 32'h40, 1'b1); wait_idle(30);
    rec = 0;
    chk("midrst_first_grant", 64'(gq.size() > 0 ? gq[0] : 1'bx), 64'(0));

    // Requester 1 valid withdrawn while requester 0 is served; last grant stays 0.
    post(0, 32'h99, 32'h1, 1'b1); drive();
    wait_phase(1);
    post(1, 32'hAAAA, 32'hBBBB, 1'b0); drive(); tick();
    pend[1] = 0; drive();
    wait_idle(20);
    gq.delete(); rec = 1;
    post(0, 32'h1, 32'h2, 1'b0); post(1, 32'h3, 32'h4, 1'b0); wait_idle(30);
    rec = 0;
    chk("withdraw_next_grant", 64'(gq.size() > 0 ? gq[0] : 1'bx), 64'(1));

    // Random traffic with backpressure and withdrawals.
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) post(r, rnd_op(), rnd_op(), 1'($urandom));
        else if (pend[r] && $urandom_range(0, 15) == 0) pend[r] = 0;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      drive(); tick();
    end
    resp_ready = 1'b1;
    wait_idle(40);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencing and arbitration controller that shares one combinational N-bit ripple-carry adder between two requesters. Each requester presents signed add/subtract operations on a valid/ready handshake; the controller grants round-robin, drives the shared adder from registered operands, and returns a registered result with carry and signed-overflow flags on a single response channel. It sits between the adder datapath and the CPU blocks that need it, such as address-increment logic and ALU add/sub.

## Interface
- N, 32, operand and result width; minimum 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  N  requester 0 operands, two's complement.
- req0_sub  in  1  1 means A−B; 0 means A+B.
- req1_valid, req1_ready, req1_a, req1_b, req1_sub: same as the requester 0 set.
- add_a, add_b  out  N  shared adder operand inputs.
- add_cin  out  1  shared adder carry-in.
- add_sum  in  N  shared adder sum, combinational from add_a, add_b and add_cin.
- add_cout  in  1  shared adder carry-out.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_id  out  1  requester that issued the result.
- resp_sum  out  N  result.
- resp_cout  out  1  adder carry-out; for subtraction, 1 means no borrow.
- resp_ovf  out  1  signed overflow.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - Arbitrate between the two requesters.
  - reqX_ready is combinational: it is 1 only in IDLE, only for the winner, and only while that requester's valid is 1.
  - A transfer occurs when reqX_valid and reqX_ready are both 1. On that edge:
    - op_a ← a;
    - op_b ← (sub ? ~b : b);
    - op_cin ← sub;
    - op_id ← X;
    - last_grant ← X;
    - state → EXEC.
  - With no valid request, the FSM stays in IDLE.
- **Round-robin arbitration**
  - If only one requester is valid, it wins.
  - If both are valid, the requester that was not last_grant wins.
  - last_grant updates only on an accepted transfer.
- **EXEC**
  - add_a, add_b and add_cin are driven from op_a, op_b and op_cin. These are always registered outputs; they hold their value in the other states.
  - At the end of the cycle, capture:
    - resp_sum ← add_sum;
    - resp_cout ← add_cout;
    - resp_ovf ← (op_a[N-1] == op_b[N-1]) && (add_sum[N-1] != op_a[N-1]);
    - resp_id ← op_id.
  - state → RESP.
- **RESP**
  - resp_valid = 1. The resp_* outputs are stable until the transfer.
  - When resp_ready is 1, state → IDLE.
  - No new request is accepted while in RESP: both ready signals are 0.
- **Requester rules**
  - Requesters hold valid and operands stable until ready.
  - Deasserting valid without a transfer is legal; nothing is latched.
- **Arithmetic**
  - Width is N bits and wraps modulo 2^N.
  - Subtraction is A + ~B + 1.
  - resp_ovf is the two's-complement overflow of the operation actually performed.

## Timing
- **Reset values**
  - state = IDLE; last_grant = 1, so requester 0 wins the first contested cycle.
  - op_a, op_b and op_cin = 0, so add_a, add_b and add_cin = 0.
  - resp_valid, resp_id, resp_sum, resp_cout and resp_ovf = 0.
  - req0_ready and req1_ready = 0 while rst is high.
- **Latency**
  - Accept edge at cycle T; EXEC in cycle T+1; resp_valid = 1 from cycle T+2.
  - Earliest next accept is the cycle after the response transfer.
  - Maximum throughput is one operation per 3 cycles with resp_ready tied high.
- **Backpressure**: resp_ready held low keeps the FSM in RESP indefinitely; requesters see ready = 0.
- **Simultaneous events**
  - A response transfer and a new request in the same cycle: the request is not accepted in that cycle. It is accepted in the following IDLE cycle.
- **Reset mid-operation**
  - Asynchronous rst in EXEC or RESP discards the in-flight operation; no response is produced.
  - After reset is released, arbitration restarts from the reset values.
- The shared adder's combinational delay must fit within one clock period (EXEC cycle).

## Test plan
- **Single add**: N=32; req0 presents a=5, b=7, sub=0.
  - Required: req0_ready=1 at T; resp_valid at T+2 with sum=12, cout=0, ovf=0, id=0.
- **Subtract and overflow**
  - req1: a=0x00000003, b=0x00000005, sub=1 → sum=0xFFFFFFFE, cout=0, ovf=0, id=1.
  - req0: a=0x7FFFFFFF, b=1, sub=0 → sum=0x80000000, ovf=1.
  - req0: a=0x80000000, b=1, sub=1 → sum=0x7FFFFFFF, ovf=1, cout=1.
- **Contention**: both requesters valid continuously with resp_ready=1.
  - Required grants: 0, 1, 0, 1, …, one accept every 3 cycles.
  - resp_id alternates, starting at 0.
- **Backpressure**: resp_ready=0 for 10 cycles while in RESP.
  - Required: resp_* stable throughout; both ready signals 0.
  - Raising resp_ready leads to IDLE, and the pending request is accepted on the next cycle.
- **Reset mid-op**: assert rst during EXEC.
  - Required: resp_valid never rises for that operation.
  - Next contested request is granted to req0.
  - add_a, add_b and add_cin are 0 immediately after rst asserts.
- **Valid withdrawal**: req1_valid pulses for 0 cycles of handshake (dropped while req0 is being served).
  - Required: no response with id=1.
  - last_grant is unaffected.
